pri_arb: RTL
============

Name: pri_arb

Overview:
- 4-requester arbiter that shares one downstream resource between requesters.
- Picks one owner per decision (fixed priority, req[3] highest) and holds the grant until the owner releases or a hold limit expires.
- Inserts one idle turnaround cycle between owners.
- Sits in front of the shared resource; consumes the raw request vector, drives one-hot grant plus encoded owner id.

Parameters:
MAX_HOLD, 16, max consecutive grant cycles per tenure; 0 disables timeout.
HCW, $clog2(MAX_HOLD+1), hold counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  synchronous enable; low forces IDLE, no grant.
req  in  4  request vector, level; req[i] held for as long as requester i wants the resource.
gnt  out  4  one-hot grant, registered; 0 when no owner.
gnt_id  out  2  encoded owner index, valid when gnt_vld=1, else 0.
gnt_vld  out  1  =|gnt.
timeout  out  1  one-cycle pulse in the PARK cycle that follows a forced preemption.

Behaviour:
- Reset: async, on rst_n low.
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - State=IDLE, hold_cnt=0, mask=0, last=0.
- States: IDLE, GRANT, PARK.
- IDLE:
  - en=1 and |req → GRANT.
  - owner = highest-index set bit of (req & ~mask), or of req if that is 0.
  - Grant visible the cycle after req is sampled (latency 1).
- GRANT:
  - gnt[owner]=1; hold_cnt increments each cycle from 0.
  - req[owner]=0 → PARK (release). gnt remains high in the cycle release is sampled and drops the next cycle.
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1 with req[owner]=1 → PARK (timeout); mask=onehot(owner), timeout=1 in the PARK cycle.
  - Release and timeout in the same cycle: treated as release; no pulse, mask=0.
- PARK:
  - gnt=0 for exactly one cycle; hold_cnt=0.
  - en=1 and |req → GRANT with a new pick using the same rule as IDLE; otherwise → IDLE.
  - mask clears once that pick is made.
  - A masked requester alone still wins (mask never starves a sole requester).
- en=0: highest precedence in any state. Next cycle IDLE, gnt=0, hold_cnt=0, mask=0, timeout=0.
- req changes for non-owners during GRANT: ignored.
- Owner re-asserting req in PARK: eligible unless masked.
- gnt_id/gnt are registered together, never disagree. gnt always one-hot or zero.
- Reset mid-GRANT: grant drops asynchronously; the first grant after reset deassertion follows IDLE rules.

Optional Feature:
PRI_ARB_RR_EN:
- Defined: round-robin pick. Search order starts at last-1, descending, wrapping 0→3; last = previous owner, updated on each GRANT entry. Timeout mask is still applied.
- Undefined: fixed priority 3>2>1>0; last is unused and may be optimised away.

Decomposition:
- Package pri_arb_pkg:
  - NREQ=4, ID_W=2.
  - State typedef with IDLE, GRANT, PARK.
  - Function onehot(id).
- Sub-module pri_pick (combinational):
  - Inputs: 4-bit vector, 2-bit start index.
  - Outputs: 2-bit id, valid.
  - Fixed-priority mode ties start to 3.
- FSM, counter and mask live in pri_arb.

Test Plan:
- rst_n=0 while gnt=4'b0100 → gnt=0, gnt_vld=0 immediately, no clock needed. After release, req=4'b0001 → gnt=4'b0001 one cycle later.
- IDLE, en=1, req=4'b0110 at cycle 0 → cycle 1: gnt=4'b0100, gnt_id=2, gnt_vld=1.
- Owner 2 drops req at cycle k, req[1]=1 → cycle k: gnt still 4'b0100; k+1: gnt=0; k+2: gnt=4'b0010, gnt_id=1.
- MAX_HOLD=4, req=4'b1001 held → sequence:
  - gnt=1000 ×4
  - 0 with timeout=1
  - 0001 ×4
  - 0 with timeout=1
  - 1000 again
- en=0 for one cycle during GRANT → next cycle gnt=0, IDLE. en=1 with req=4'b1000 → gnt=4'b1000 one cycle later, timeout never pulses.
- MAX_HOLD=2, req=4'b1111 held:
  - PRI_ARB_RR_EN defined → owner ids 3,2,1,0,3.
  - PRI_ARB_RR_EN undefined → owner ids 3,2,3,2.

Source files
------------

// File: rtl/pri_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pri_arb_pkg
// Purpose  : Shared constants, FSM state type and helpers for the pri_arb
//            4-requester arbiter.
// Revision : 1.0  initial release
// ============================================================================
package pri_arb_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PARK  = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pri_pick.sv
`default_nettype none
// ============================================================================
// Module   : pri_pick
// Purpose  : Combinational picker: first set bit of vec searching downward
//            from index start, wrapping 0 -> NREQ-1.
// Revision : 1.0  initial release
// ============================================================================
module pri_pick
  import pri_arb_pkg::*;
(
  input  logic [NREQ-1:0] vec,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // Walk from lowest to highest priority so the last hit (start itself) wins.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (vec[start - ID_W'(i)]) begin
        id    = start - ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pri_arb.sv
`default_nettype none
// ============================================================================
// Module   : pri_arb
// Purpose  : 4-requester arbiter with hold-limit preemption and a one-cycle
//            turnaround between owners. Define PRI_ARB_RR_EN for round-robin
//            picking; default is fixed priority req[3] > ... > req[0].
// Revision : 1.0  initial release
// ============================================================================
module pri_arb
  import pri_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  state_t          state;
  logic [HCW-1:0]  hold_cnt;
  logic [NREQ-1:0] mask;
  logic [ID_W-1:0] start;
  logic [NREQ-1:0] masked_req;
  logic [NREQ-1:0] pick_vec;
  logic [ID_W-1:0] pick_id;
  logic            pick_vld;
  logic            owner_req;
  logic            hold_hit;

`ifdef PRI_ARB_RR_EN
  logic [ID_W-1:0] last;
  assign start = last - ID_W'(1);
`else
  assign start = ID_W'(NREQ - 1);
`endif

  // A masked requester that is alone still wins: fall back to the raw vector.
  assign masked_req = req & ~mask;
  assign pick_vec   = (|masked_req) ? masked_req : req;

  pri_pick u_pick (
    .vec   (pick_vec),
    .start (start),
    .id    (pick_id),
    .valid (pick_vld)
  );

  assign owner_req = req[gnt_id];
  assign hold_hit  = HOLD_EN && (hold_cnt == HOLD_LAST);
  assign gnt_vld   = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      mask     <= '0;
`ifdef PRI_ARB_RR_EN
      last     <= '0;
`endif
    end else if (!en) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      mask     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, PARK: begin
          hold_cnt <= '0;
          if (pick_vld) begin
            state  <= GRANT;
            gnt    <= onehot(pick_id);
            gnt_id <= pick_id;
            mask   <= '0;
`ifdef PRI_ARB_RR_EN
            last   <= pick_id;
`endif
          end else begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
          end
        end
        GRANT: begin
          // Release takes precedence over a coincident hold-limit expiry.
          if (!owner_req) begin
            state    <= PARK;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            mask     <= '0;
          end else if (hold_hit) begin
            state    <= PARK;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            mask     <= onehot(gnt_id);
            timeout  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HCW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          gnt_id   <= '0;
          hold_cnt <= '0;
          mask     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
